// File: rtl/cache_ctrl.sv
// Direct-mapped write-through cache controller between the core load/store port and main memory.
// Latency: load hit 0 cycles; load miss = memory ack latency + 1 stall cycles; store = ack latency + 1 stall cycles, then one DONE cycle.
// Backpressure: stall holds the core while a miss or store is outstanding; memory paces completion with the one-cycle mem_ack strobe.
module cache_ctrl #(
  parameter int INDEX_BITS = 7,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MWR,
  input  logic             MOE,
  input  logic [31:0]      Adr,
  input  logic [31:0]      MWD,
  output logic [31:0]      CRD,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_adr,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int TAG_W = 30 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t state, state_nxt;

  // Valid bits need a reset; tags and data behave like plain RAM and do not.
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [INDEX_BITS-1:0] idx, fill_idx, line_idx;
  logic [TAG_W-1:0]      tag, fill_tag, line_tag;
  logic [31:0]           line_dat;
  logic                  hit, idle, do_store, do_hit, do_miss, fill_done, line_we;

  // Byte offset bits carry no information for a word-organised cache.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^Adr[1:0];

  assign idx      = Adr[INDEX_BITS+1:2];
  assign tag      = Adr[31:INDEX_BITS+2];
  // A fill lands at the address already registered on the memory port, not the live core address.
  assign fill_idx = mem_adr[INDEX_BITS+1:2];
  assign fill_tag = mem_adr[31:INDEX_BITS+2];

  assign hit       = MOE & valid_q[idx] & (tag_mem[idx] == tag);
  assign idle      = (state == IDLE);
  assign do_store  = idle & MWR;
  assign do_hit    = idle & ~MWR & hit;
  assign do_miss   = idle & ~MWR & MOE & ~hit;
  assign fill_done = (state == FILL) & mem_ack;

  // Store (write-allocate) and fill completion never coincide, so one write port serves both.
  assign line_we  = do_store | fill_done;
  assign line_idx = fill_done ? fill_idx : idx;
  assign line_tag = fill_done ? fill_tag : tag;
  assign line_dat = fill_done ? mem_rd   : MWD;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; mem_ack only matters while a transaction is open
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (do_store) state_nxt = WRITE;
               else if (do_miss) state_nxt = FILL;
      FILL:    if (mem_ack) state_nxt = IDLE;
      WRITE:   if (mem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Core-facing outputs: data only on an IDLE hit, stall while anything is outstanding
  always_comb begin
    stall = ~rst & (do_store | do_miss | (state == FILL) | (state == WRITE));
    CRD   = (~rst & do_hit) ? data_mem[idx] : 32'h0;
  end

  // Memory port registers, valid bits and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_adr  <= 32'h0;
      mem_wd   <= 32'h0;
      valid_q  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (do_store) begin
        mem_req <= 1'b1;
        mem_we  <= 1'b1;
        mem_adr <= {Adr[31:2], 2'b00};
        mem_wd  <= MWD;
      end else if (do_miss) begin
        mem_req <= 1'b1;
        mem_we  <= 1'b0;
        mem_adr <= {Adr[31:2], 2'b00};
      end else if (((state == FILL) || (state == WRITE)) && mem_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (line_we) valid_q[line_idx] <= 1'b1;
      if (do_hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + CNT_W'(1);
      if (do_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  // Tag/data array write
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[line_idx]  <= line_tag;
      data_mem[line_idx] <= line_dat;
    end
  end

endmodule
